// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA pin-side timing checker, lock tracker and target-colour bounding box
module vga_rx_monitor #(
    parameter int          H_TOTAL     = 1056,
    parameter int          H_SYNC      = 128,
    parameter int          H_BACK      = 88,
    parameter int          H_ACTIVE    = 800,
    parameter int          V_TOTAL     = 628,
    parameter int          V_SYNC      = 4,
    parameter int          V_BACK      = 23,
    parameter int          V_ACTIVE    = 600,
    parameter logic [11:0] TARGET_RGB  = 12'hFFF,
    parameter int          LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        frame_done,
    output logic        obj_found,
    output logic [10:0] obj_xmin,
    output logic [10:0] obj_xmax,
    output logic [10:0] obj_ymin,
    output logic [10:0] obj_ymax,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_OFF   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] Y_OFF   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] X_LIM   = 11'(H_ACTIVE);
    localparam logic [10:0] Y_LIM   = 11'(V_ACTIVE);
    localparam logic [10:0] V_LINES = 11'(V_TOTAL);
    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam int          GW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ALIGN, TRACK} state_t;

    state_t        state;
    logic          hs_r, hs_p, vs_r, vs_p;
    logic [11:0]   rgb_r, rgb_p;
    logic [10:0]   hcnt, vline;
    logic          err_seen;
    logic [GW-1:0] good_cnt;
    logic          w_hit;
    logic [10:0]   w_xmin, w_xmax, w_ymin, w_ymax;

    logic          hs_edge, vs_edge, active, hit;
    logic          line_bad, timeout, line_err_det, frame_end, frame_bad, frame_ok;
    logic [10:0]   x, y, lines_now;
    logic [GW-1:0] good_inc;

    // rgb_p lags rgb_r by one cycle so it lines up with the registered hcnt/vline
    assign hs_edge      = hs_r & ~hs_p;
    assign vs_edge      = vs_r & ~vs_p;
    assign x            = hcnt - X_OFF;
    assign y            = vline - Y_OFF;
    assign active       = (hcnt >= X_OFF) && (x < X_LIM) && (vline >= Y_OFF) && (y < Y_LIM);
    assign hit          = (state == TRACK) && active && (rgb_p == TARGET_RGB);
    assign line_bad     = (state == TRACK) && hs_edge && (hcnt != H_LAST);
    assign timeout      = (state == TRACK) && !hs_edge && (hcnt == CNT_MAX);
    assign line_err_det = line_bad || timeout;
    assign frame_end    = (state == TRACK) && vs_edge && !timeout;
    assign lines_now    = vline + 11'(hs_edge);
    assign frame_bad    = (lines_now != V_LINES);
    assign frame_ok     = !err_seen && !line_err_det && !frame_bad;
    assign good_inc     = (good_cnt == GOOD_MAX) ? GOOD_MAX : good_cnt + GW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            hs_r       <= 1'b0;
            hs_p       <= 1'b0;
            vs_r       <= 1'b0;
            vs_p       <= 1'b0;
            rgb_r      <= '0;
            rgb_p      <= '0;
            hcnt       <= '0;
            vline      <= '0;
            err_seen   <= 1'b0;
            good_cnt   <= '0;
            w_hit      <= 1'b0;
            w_xmin     <= '0;
            w_xmax     <= '0;
            w_ymin     <= '0;
            w_ymax     <= '0;
            locked     <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            obj_found  <= 1'b0;
            obj_xmin   <= '0;
            obj_xmax   <= '0;
            obj_ymin   <= '0;
            obj_ymax   <= '0;
            frame_cnt  <= '0;
        end else begin
            hs_r  <= hsync;
            hs_p  <= hs_r;
            vs_r  <= vsync;
            vs_p  <= vs_r;
            rgb_r <= rgb;
            rgb_p <= rgb_r;

            line_err   <= line_err_det;
            frame_err  <= frame_end && frame_bad;
            frame_done <= frame_end;

            if (vs_edge)
                err_seen <= 1'b0;
            else if (line_err_det)
                err_seen <= 1'b1;

            if (line_err || frame_err)
                locked <= 1'b0;
            if (line_err_det)
                good_cnt <= '0;

            case (state)
                SEARCH: begin
                    hcnt <= '0;
                    if (vs_edge) begin
                        vline <= '0;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (hs_edge) begin
                        hcnt  <= '0;
                        vline <= vs_edge ? 11'd0 : vline + 11'd1;
                        state <= TRACK;
                    end else if (vs_edge) begin
                        vline <= '0;
                    end
                end
                TRACK: begin
                    if (hs_edge)
                        hcnt <= '0;
                    else if (hcnt != CNT_MAX)
                        hcnt <= hcnt + 11'd1;

                    if (vs_edge)
                        vline <= '0;
                    else if (hs_edge && vline != CNT_MAX)
                        vline <= vline + 11'd1;

                    if (timeout) begin
                        state    <= SEARCH;
                        hcnt     <= '0;
                        vline    <= '0;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end

                    if (frame_end) begin
                        obj_found <= w_hit;
                        obj_xmin  <= w_hit ? w_xmin : 11'd0;
                        obj_xmax  <= w_hit ? w_xmax : 11'd0;
                        obj_ymin  <= w_hit ? w_ymin : 11'd0;
                        obj_ymax  <= w_hit ? w_ymax : 11'd0;
                        frame_cnt <= frame_cnt + 16'd1;
                        if (frame_ok) begin
                            good_cnt <= good_inc;
                            locked   <= (good_inc == GOOD_MAX);
                        end else begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end
                end
                default: state <= SEARCH;
            endcase

            // Working box only accumulates while tracking and restarts at every frame boundary
            if (state != TRACK || frame_end || timeout) begin
                w_hit  <= 1'b0;
                w_xmin <= '0;
                w_xmax <= '0;
                w_ymin <= '0;
                w_ymax <= '0;
            end else if (hit) begin
                w_hit <= 1'b1;
                if (!w_hit) begin
                    w_xmin <= x;
                    w_xmax <= x;
                    w_ymin <= y;
                    w_ymax <= y;
                end else begin
                    if (x < w_xmin) w_xmin <= x;
                    if (x > w_xmax) w_xmax <= x;
                    if (y < w_ymin) w_ymin <= y;
                    if (y > w_ymax) w_ymax <= y;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed bench for vga_rx_monitor on a scaled-down 64x40 raster
module tb_vga_rx_monitor;

    localparam int H_TOTAL = 64;
    localparam int H_SYNC  = 8;
    localparam int H_BACK  = 8;
    localparam int H_ACT   = 40;
    localparam int V_TOTAL = 40;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 3;
    localparam int V_ACT   = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync;
    logic [11:0] rgb;
    logic        locked, line_err, frame_err, frame_done, obj_found;
    logic [10:0] obj_xmin, obj_xmax, obj_ymin, obj_ymax;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_n    = 0;
    int le_n    = 0;
    int fe_n    = 0;

    logic        r_found [32];
    logic [43:0] r_box   [32];
    logic        r_lock  [32];
    logic [15:0] r_cnt   [32];

    vga_rx_monitor #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACT),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACT),
        .TARGET_RGB(12'hFFF), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .locked(locked), .line_err(line_err), .frame_err(frame_err),
        .frame_done(frame_done), .obj_found(obj_found),
        .obj_xmin(obj_xmin), .obj_xmax(obj_xmax), .obj_ymin(obj_ymin), .obj_ymax(obj_ymax),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            if (fd_n < 32) begin
                r_found[fd_n] = obj_found;
                r_box[fd_n]   = {obj_xmin, obj_xmax, obj_ymin, obj_ymax};
                r_lock[fd_n]  = locked;
                r_cnt[fd_n]   = frame_cnt;
            end
            fd_n++;
        end
        if (line_err)  le_n++;
        if (frame_err) fe_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: background only, 1: 5x5 square at x10..14 y20..24 plus decoys, 2: active-area corners
    function automatic logic [11:0] pix(input int mode, input int v, input int h);
        logic act;
        act = (h >= 16) && (h < 56) && (v >= 5) && (v < 35);
        if (mode == 1) begin
            if (h >= 26 && h <= 30 && v >= 25 && v <= 29) return 12'hFFF;
            if ((h == 3 && v == 10) || (h == 56 && v == 12) || (h == 15 && v == 12) ||
                (h == 20 && v == 4) || (h == 20 && v == 35)) return 12'hFFF;
            if (h == 40 && v == 15) return 12'hFFE;
        end
        if (mode == 2) begin
            if ((h == 16 && v == 5) || (h == 55 && v == 34)) return 12'hFFF;
        end
        return act ? 12'h0F0 : 12'h000;
    endfunction

    task automatic gen_lines(input int v0, input int v1, input int short_line, input int mode);
        for (int v = v0; v < v1; v++) begin
            int len;
            len = (v == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                @(negedge clk);
                hsync = (h < H_SYNC);
                vsync = (v < V_SYNC);
                rgb   = pix(mode, v, h);
            end
        end
    endtask

    task automatic check_done(input int k, input logic found, input logic [43:0] box,
                              input logic lk, input logic [15:0] cnt);
        check($sformatf("done%0d_found", k), r_found[k-1], found);
        check($sformatf("done%0d_box", k), r_box[k-1], box);
        check($sformatf("done%0d_locked", k), r_lock[k-1], lk);
        check($sformatf("done%0d_cnt", k), r_cnt[k-1], cnt);
    endtask

    localparam logic [43:0] SQ_BOX   = {11'd10, 11'd14, 11'd20, 11'd24};
    localparam logic [43:0] CORN_BOX = {11'd0, 11'd39, 11'd0, 11'd29};

    initial begin
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; rgb = '0;
        repeat (5) @(negedge clk);
        check("reset_flags", {locked, line_err, frame_err, frame_done, obj_found}, 0);
        check("reset_box", {obj_xmin, obj_xmax, obj_ymin, obj_ymax}, 0);
        check("reset_cnt", frame_cnt, 0);
        rst = 1'b0;

        gen_lines(0, 40, -1, 1);
        check("align_no_done", fd_n, 0);
        gen_lines(0, 40, -1, 1);
        gen_lines(0, 40, -1, 2);
        gen_lines(0, 40, -1, 0);
        gen_lines(0, 40, -1, 0);
        check("done_count_4", fd_n, 4);
        check_done(1, 1'b1, SQ_BOX, 1'b0, 16'd1);
        check_done(2, 1'b1, SQ_BOX, 1'b1, 16'd2);
        check_done(3, 1'b1, CORN_BOX, 1'b1, 16'd3);
        check_done(4, 1'b0, 44'd0, 1'b1, 16'd4);
        check("locked_before_timeout", locked, 1'b1);
        check("no_line_err_yet", le_n, 0);

        repeat (2100) begin
            @(negedge clk);
            hsync = 1'b0; vsync = 1'b0; rgb = '0;
        end
        check("timeout_line_err", le_n, 1);
        check("timeout_unlocked", locked, 1'b0);

        gen_lines(0, 40, -1, 1);
        check("search_no_done", fd_n, 4);
        gen_lines(0, 40, -1, 1);
        gen_lines(0, 40, 10, 1);
        check("short_line_err", le_n, 2);
        check("short_line_unlocked", locked, 1'b0);
        gen_lines(0, 40, -1, 1);
        gen_lines(0, 40, -1, 1);
        gen_lines(0, 39, -1, 0);
        gen_lines(0, 40, -1, 1);
        gen_lines(0, 20, -1, 1);
        check("done_count_11", fd_n, 11);
        check_done(5, 1'b1, SQ_BOX, 1'b0, 16'd5);
        check_done(6, 1'b1, SQ_BOX, 1'b1, 16'd6);
        check_done(7, 1'b1, SQ_BOX, 1'b0, 16'd7);
        check_done(8, 1'b1, SQ_BOX, 1'b0, 16'd8);
        check_done(9, 1'b1, SQ_BOX, 1'b1, 16'd9);
        check_done(10, 1'b0, 44'd0, 1'b0, 16'd10);
        check_done(11, 1'b1, SQ_BOX, 1'b0, 16'd11);
        check("frame_err_count", fe_n, 1);
        check("line_err_total", le_n, 2);

        @(negedge clk);
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; rgb = '0;
        repeat (3) @(negedge clk);
        check("midrst_flags", {locked, line_err, frame_err, frame_done, obj_found}, 0);
        check("midrst_box", {obj_xmin, obj_xmax, obj_ymin, obj_ymax}, 0);
        check("midrst_cnt", frame_cnt, 0);
        rst = 1'b0;

        gen_lines(20, 40, -1, 1);
        gen_lines(0, 40, -1, 1);
        check("post_rst_first_vs_no_done", fd_n, 11);
        gen_lines(0, 1, -1, 0);
        check("post_rst_done", fd_n, 12);
        check_done(12, 1'b1, SQ_BOX, 1'b0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
